// File: rtl/bram_arb_pkg.sv
// Shared types for the BRAM port-A arbiter: response owner, arbiter state and
// the response-pipeline entry.
package bram_arb_pkg;

    typedef enum logic {
        OWN_LK  = 1'b0,
        OWN_CFG = 1'b1
    } owner_e;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef struct packed {
        logic   valid;
        owner_e owner;
    } rsp_entry_t;

endpackage

// File: rtl/bram_arb_rsp_pipe.sv
// READ_LAT-deep {valid, owner} shift register that steers BRAM read data to the
// owner of each read; the non-owner's data output holds its last value.
module bram_arb_rsp_pipe
    import bram_arb_pkg::*;
#(
    parameter int unsigned READ_LAT   = 1,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_push_valid,
    input  logic                  i_push_owner,
    input  logic [DATA_WIDTH-1:0] i_bram_dout,
    output logic                  o_lk_rsp_valid,
    output logic [DATA_WIDTH-1:0] o_lk_rsp_data,
    output logic                  o_cfg_rsp_valid,
    output logic [DATA_WIDTH-1:0] o_cfg_rsp_data
);

    rsp_entry_t            r_pipe [READ_LAT];
    rsp_entry_t            w_exit;
    logic                  w_lk_hit;
    logic                  w_cfg_hit;
    logic [DATA_WIDTH-1:0] r_lk_hold;
    logic [DATA_WIDTH-1:0] r_cfg_hold;

    assign w_exit    = r_pipe[READ_LAT-1];
    assign w_lk_hit  = w_exit.valid && (w_exit.owner == OWN_LK);
    assign w_cfg_hit = w_exit.valid && (w_exit.owner == OWN_CFG);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < READ_LAT; i++) begin
                r_pipe[i] <= '{valid: 1'b0, owner: OWN_LK};
            end
            r_lk_hold  <= '0;
            r_cfg_hold <= '0;
        end else begin
            r_pipe[0] <= '{valid: i_push_valid, owner: owner_e'(i_push_owner)};
            for (int i = 1; i < READ_LAT; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
            if (w_lk_hit) begin
                r_lk_hold <= i_bram_dout;
            end
            if (w_cfg_hit) begin
                r_cfg_hold <= i_bram_dout;
            end
        end
    end

    // The owner sees live BRAM data on its valid cycle; the hold register keeps it afterwards.
    always_comb begin
        o_lk_rsp_valid  = w_lk_hit;
        o_cfg_rsp_valid = w_cfg_hit;
        o_lk_rsp_data   = w_lk_hit ? i_bram_dout : r_lk_hold;
        o_cfg_rsp_data  = w_cfg_hit ? i_bram_dout : r_cfg_hold;
    end

endmodule

// File: rtl/bram_port_arbiter.sv
// Port-A arbiter for the match-table BRAM: zero-fills after reset, then grants lookup
// or config with aging. Optional grant statistics under BRAM_ARB_STATS_EN.
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int unsigned NUM_COL    = 4,
    parameter int unsigned COL_WIDTH  = 8,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned READ_LAT   = 1,
    parameter int unsigned MAX_WAIT   = 4,
    localparam int unsigned DATA_WIDTH = NUM_COL * COL_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_lk_valid,
    output logic                  o_lk_ready,
    input  logic [ADDR_WIDTH-1:0] i_lk_addr,
    output logic                  o_lk_rsp_valid,
    output logic [DATA_WIDTH-1:0] o_lk_rsp_data,
    input  logic                  i_cfg_valid,
    output logic                  o_cfg_ready,
    input  logic [NUM_COL-1:0]    i_cfg_we,
    input  logic [ADDR_WIDTH-1:0] i_cfg_addr,
    input  logic [DATA_WIDTH-1:0] i_cfg_din,
    output logic                  o_cfg_rsp_valid,
    output logic [DATA_WIDTH-1:0] o_cfg_rsp_data,
    output logic                  o_init_done,
    output logic                  o_bram_en,
    output logic [NUM_COL-1:0]    o_bram_we,
    output logic [ADDR_WIDTH-1:0] o_bram_addr,
    output logic [DATA_WIDTH-1:0] o_bram_din,
    input  logic [DATA_WIDTH-1:0] i_bram_dout
`ifdef BRAM_ARB_STATS_EN
    ,
    input  logic                  i_stat_clr,
    output logic [31:0]           o_stat_lk_grants,
    output logic [31:0]           o_stat_cfg_grants,
    output logic [31:0]           o_stat_forced
`endif
);

    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

    state_e                r_state;
    state_e                w_state_next;
    logic [ADDR_WIDTH-1:0] r_init_addr;
    logic [WAIT_W-1:0]     r_wait_cnt;
    logic [WAIT_W-1:0]     w_wait_next;
    logic                  w_forced;
    logic                  w_lk_grant;
    logic                  w_cfg_grant;
    logic                  w_push_valid;
    owner_e                w_push_owner;

    always_comb begin
        w_state_next = r_state;
        w_wait_next  = '0;
        w_forced     = 1'b0;
        w_lk_grant   = 1'b0;
        w_cfg_grant  = 1'b0;
        o_bram_en    = 1'b0;
        o_bram_we    = '0;
        o_bram_addr  = '0;
        o_bram_din   = i_cfg_din;
        // Gated by rst so the port is idle in the reset cycle itself.
        if (!i_rst) begin
            unique case (r_state)
                ST_INIT: begin
                    o_bram_en   = 1'b1;
                    o_bram_we   = '1;
                    o_bram_addr = r_init_addr;
                    o_bram_din  = '0;
                    if (r_init_addr == '1) begin
                        w_state_next = ST_RUN;
                    end
                end
                ST_RUN: begin
                    w_forced    = i_cfg_valid && (r_wait_cnt == WAIT_W'(MAX_WAIT));
                    w_cfg_grant = i_cfg_valid && (w_forced || !i_lk_valid);
                    w_lk_grant  = i_lk_valid && !w_cfg_grant;
                    if (w_cfg_grant) begin
                        o_bram_en   = 1'b1;
                        o_bram_we   = i_cfg_we;
                        o_bram_addr = i_cfg_addr;
                    end else if (w_lk_grant) begin
                        o_bram_en   = 1'b1;
                        o_bram_addr = i_lk_addr;
                    end
                    if (i_cfg_valid && !w_cfg_grant) begin
                        w_wait_next = (r_wait_cnt == WAIT_W'(MAX_WAIT)) ? r_wait_cnt
                                                                        : r_wait_cnt + WAIT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_lk_ready   = w_lk_grant;
    assign o_cfg_ready  = w_cfg_grant;
    assign o_init_done  = !i_rst && (r_state == ST_RUN);
    assign w_push_valid = w_lk_grant || (w_cfg_grant && (i_cfg_we == '0));
    assign w_push_owner = w_cfg_grant ? OWN_CFG : OWN_LK;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_INIT;
            r_init_addr <= '0;
            r_wait_cnt  <= '0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_next;
            if (r_state == ST_INIT) begin
                r_init_addr <= r_init_addr + ADDR_WIDTH'(1);
            end
        end
    end

    bram_arb_rsp_pipe #(
        .READ_LAT   (READ_LAT),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rsp_pipe (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_push_valid    (w_push_valid),
        .i_push_owner    (w_push_owner),
        .i_bram_dout     (i_bram_dout),
        .o_lk_rsp_valid  (o_lk_rsp_valid),
        .o_lk_rsp_data   (o_lk_rsp_data),
        .o_cfg_rsp_valid (o_cfg_rsp_valid),
        .o_cfg_rsp_data  (o_cfg_rsp_data)
    );

`ifdef BRAM_ARB_STATS_EN
    logic [31:0] r_stat_lk;
    logic [31:0] r_stat_cfg;
    logic [31:0] r_stat_forced;

    // Clear has priority over a same-cycle increment.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_stat_clr) begin
            r_stat_lk     <= '0;
            r_stat_cfg    <= '0;
            r_stat_forced <= '0;
        end else begin
            if (w_lk_grant && (r_stat_lk != '1)) begin
                r_stat_lk <= r_stat_lk + 32'd1;
            end
            if (w_cfg_grant && (r_stat_cfg != '1)) begin
                r_stat_cfg <= r_stat_cfg + 32'd1;
            end
            if (w_forced && (r_stat_forced != '1)) begin
                r_stat_forced <= r_stat_forced + 32'd1;
            end
        end
    end

    assign o_stat_lk_grants  = r_stat_lk;
    assign o_stat_cfg_grants = r_stat_cfg;
    assign o_stat_forced     = r_stat_forced;
`endif

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: behavioural BRAM plus a rule-level reference model of the
// table contents, arbitration and response ordering. Stats checks need BRAM_ARB_STATS_EN.
module tb_bram_port_arbiter;

    localparam int NC    = 4;
    localparam int CW    = 8;
    localparam int AW    = 4;
    localparam int RL    = 2;
    localparam int MW    = 4;
    localparam int DW    = NC * CW;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          lk_valid, lk_ready, lk_rsp_valid;
    logic [AW-1:0] lk_addr;
    logic [DW-1:0] lk_rsp_data;
    logic          cfg_valid, cfg_ready, cfg_rsp_valid;
    logic [NC-1:0] cfg_we;
    logic [AW-1:0] cfg_addr;
    logic [DW-1:0] cfg_din, cfg_rsp_data;
    logic          init_done, bram_en;
    logic [NC-1:0] bram_we;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_din, bram_dout;
    logic          stat_clr;
    logic [31:0]   stat_lk, stat_cfg, stat_forced;

    always #5 clk = ~clk;

    bram_port_arbiter #(
        .NUM_COL    (NC),
        .COL_WIDTH  (CW),
        .ADDR_WIDTH (AW),
        .READ_LAT   (RL),
        .MAX_WAIT   (MW)
    ) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_lk_valid      (lk_valid),
        .o_lk_ready      (lk_ready),
        .i_lk_addr       (lk_addr),
        .o_lk_rsp_valid  (lk_rsp_valid),
        .o_lk_rsp_data   (lk_rsp_data),
        .i_cfg_valid     (cfg_valid),
        .o_cfg_ready     (cfg_ready),
        .i_cfg_we        (cfg_we),
        .i_cfg_addr      (cfg_addr),
        .i_cfg_din       (cfg_din),
        .o_cfg_rsp_valid (cfg_rsp_valid),
        .o_cfg_rsp_data  (cfg_rsp_data),
        .o_init_done     (init_done),
        .o_bram_en       (bram_en),
        .o_bram_we       (bram_we),
        .o_bram_addr     (bram_addr),
        .o_bram_din      (bram_din),
        .i_bram_dout     (bram_dout)
`ifdef BRAM_ARB_STATS_EN
        ,
        .i_stat_clr        (stat_clr),
        .o_stat_lk_grants  (stat_lk),
        .o_stat_cfg_grants (stat_cfg),
        .o_stat_forced     (stat_forced)
`endif
    );

`ifndef BRAM_ARB_STATS_EN
    assign stat_lk     = '0;
    assign stat_cfg    = '0;
    assign stat_forced = '0;
`endif

    // Behavioural byte-write BRAM with RL-cycle read latency; scramble loads junk contents.
    logic [DW-1:0] bram_mem  [DEPTH];
    logic [DW-1:0] bram_pipe [RL];
    logic          scramble = 1'b0;

    always @(posedge clk) begin
        if (scramble) begin
            for (int i = 0; i < DEPTH; i++) bram_mem[i] <= $urandom;
        end else if (bram_en) begin
            bram_pipe[0] <= bram_mem[bram_addr];
            for (int c = 0; c < NC; c++) begin
                if (bram_we[c]) bram_mem[bram_addr][c*CW +: CW] <= bram_din[c*CW +: CW];
            end
        end
        for (int i = 1; i < RL; i++) bram_pipe[i] <= bram_pipe[i-1];
    end
    assign bram_dout = bram_pipe[RL-1];

    // Reference model.
    typedef struct {
        int            due;
        bit            own_cfg;
        logic [DW-1:0] data;
    } exp_t;

    logic [DW-1:0] ref_mem [DEPTH];
    exp_t          exp_q[$];
    int            ref_wait;
    logic [DW-1:0] last_lk, last_cfg;
    int            m_lk, m_cfg, m_forced;
    int            cyc;
    int            n_checks;
    int            n_errors;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // One RUN cycle: check this cycle's outputs against the model, then advance the model.
    task automatic tick();
        logic forced, lk_g, cfg_g, exp_lkv, exp_cfgv;
        exp_t e;
        @(negedge clk);
        forced = cfg_valid && (ref_wait >= MW);
        cfg_g  = cfg_valid && (forced || !lk_valid);
        lk_g   = lk_valid && !cfg_g;
        check("init_done", init_done, 1);
        check("lk_ready", lk_ready, lk_g);
        check("cfg_ready", cfg_ready, cfg_g);
        check("bram_en", bram_en, lk_g || cfg_g);
        if (cfg_g) begin
            check("bram_addr_cfg", bram_addr, cfg_addr);
            check("bram_we_cfg", bram_we, cfg_we);
            check("bram_din_cfg", bram_din, cfg_din);
        end else if (lk_g) begin
            check("bram_addr_lk", bram_addr, lk_addr);
            check("bram_we_lk", bram_we, 0);
        end else begin
            check("bram_we_idle", bram_we, 0);
        end
        exp_lkv  = 1'b0;
        exp_cfgv = 1'b0;
        if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            if (e.own_cfg) begin
                exp_cfgv = 1'b1;
                last_cfg = e.data;
            end else begin
                exp_lkv = 1'b1;
                last_lk = e.data;
            end
        end
        check("lk_rsp_valid", lk_rsp_valid, exp_lkv);
        check("cfg_rsp_valid", cfg_rsp_valid, exp_cfgv);
        check("lk_rsp_data", lk_rsp_data, last_lk);
        check("cfg_rsp_data", cfg_rsp_data, last_cfg);
`ifdef BRAM_ARB_STATS_EN
        check("stat_lk", stat_lk, m_lk);
        check("stat_cfg", stat_cfg, m_cfg);
        check("stat_forced", stat_forced, m_forced);
        if (stat_clr) begin
            m_lk = 0; m_cfg = 0; m_forced = 0;
        end else begin
            if (lk_g) m_lk++;
            if (cfg_g) m_cfg++;
            if (cfg_g && forced) m_forced++;
        end
`endif
        if (cfg_g) begin
            if (cfg_we == '0) begin
                exp_q.push_back('{due: cyc + RL, own_cfg: 1'b1, data: ref_mem[cfg_addr]});
            end else begin
                for (int c = 0; c < NC; c++) begin
                    if (cfg_we[c]) ref_mem[cfg_addr][c*CW +: CW] = cfg_din[c*CW +: CW];
                end
            end
        end
        if (lk_g) exp_q.push_back('{due: cyc + RL, own_cfg: 1'b0, data: ref_mem[lk_addr]});
        if (cfg_valid && !cfg_g) ref_wait = (ref_wait < MW) ? ref_wait + 1 : MW;
        else ref_wait = 0;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_idle();
        lk_valid  = 1'b0;
        cfg_valid = 1'b0;
        cfg_we    = '0;
        stat_clr  = 1'b0;
    endtask

    // Hold reset for `hold` edges (first edge scrambles the BRAM), check reset outputs,
    // then run INIT checking the zero-fill sweep.
    task automatic do_reset(input int hold);
        rst = 1'b1;
        set_idle();
        scramble = 1'b1;
        @(posedge clk); #1; cyc++;
        scramble = 1'b0;
        for (int h = 1; h < hold; h++) begin
            @(posedge clk); #1; cyc++;
        end
        @(negedge clk);
        check("rst_init_done", init_done, 0);
        check("rst_lk_ready", lk_ready, 0);
        check("rst_cfg_ready", cfg_ready, 0);
        check("rst_bram_en", bram_en, 0);
        check("rst_bram_we", bram_we, 0);
        check("rst_lk_rsp_valid", lk_rsp_valid, 0);
        check("rst_cfg_rsp_valid", cfg_rsp_valid, 0);
        check("rst_lk_rsp_data", lk_rsp_data, 0);
        check("rst_cfg_rsp_data", cfg_rsp_data, 0);
        @(posedge clk); #1; cyc++;
        rst = 1'b0;
        exp_q.delete();
        ref_wait = 0;
        last_lk  = '0;
        last_cfg = '0;
        m_lk = 0; m_cfg = 0; m_forced = 0;
        lk_valid  = 1'b1;
        cfg_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            check("init_en", bram_en, 1);
            check("init_we", bram_we, {NC{1'b1}});
            check("init_addr", bram_addr, i);
            check("init_din", bram_din, 0);
            check("init_lk_ready", lk_ready, 0);
            check("init_cfg_ready", cfg_ready, 0);
            check("init_done_low", init_done, 0);
            @(posedge clk); #1; cyc++;
        end
        set_idle();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        lk_addr  = '0;
        cfg_addr = '0;
        cfg_din  = '0;
        do_reset(2);

        // Lone masked write then read-back of the same word.
        cfg_valid = 1'b1; cfg_we = 4'b0011; cfg_addr = 4'd3; cfg_din = 32'hAABBCCDD;
        tick();
        cfg_we = '0;
        tick();
        set_idle();
        repeat (RL + 1) tick();

        // Both requesters saturated: aging forces every fifth grant to config.
        lk_valid = 1'b1; cfg_valid = 1'b1; cfg_we = '0;
        for (int i = 0; i < 15; i++) begin
            lk_addr  = AW'($urandom);
            cfg_addr = AW'($urandom);
            tick();
        end
        set_idle();

        // Distinct words at 5 and 6, then alternating lookup/config reads.
        cfg_valid = 1'b1; cfg_we = '1; cfg_addr = 4'd5; cfg_din = 32'h5555A5A5;
        tick();
        cfg_addr = 4'd6; cfg_din = 32'h66665A5A;
        tick();
        set_idle();
        for (int i = 0; i < 6; i++) begin
            lk_valid = 1'b1; lk_addr = 4'd5; cfg_valid = 1'b0;
            tick();
            lk_valid = 1'b0; cfg_valid = 1'b1; cfg_we = '0; cfg_addr = 4'd6;
            tick();
        end
        set_idle();
        repeat (RL + 1) tick();

        // Random traffic, including back-to-back write/read of the same address.
        for (int i = 0; i < 300; i++) begin
            lk_valid  = ($urandom_range(0, 2) != 0);
            cfg_valid = ($urandom_range(0, 1) != 0);
            lk_addr   = AW'($urandom);
            cfg_addr  = ($urandom_range(0, 3) == 0) ? lk_addr : AW'($urandom);
            cfg_we    = ($urandom_range(0, 1) != 0) ? NC'(0) : NC'($urandom);
            cfg_din   = $urandom;
            tick();
        end
        set_idle();
        repeat (RL + 1) tick();
        check("drain_queue", exp_q.size(), 0);

        // Reset while a lookup read is in flight: its response must never appear.
        lk_valid = 1'b1; lk_addr = 4'd5;
        tick();
        do_reset(1);
        repeat (RL + 1) tick();

`ifdef BRAM_ARB_STATS_EN
        // Ten lookup grants, clear on the eleventh; counter reads zero afterwards.
        lk_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            lk_addr = AW'($urandom);
            tick();
        end
        stat_clr = 1'b1;
        tick();
        set_idle();
        repeat (RL + 1) tick();
        check("stat_lk_after_clr", stat_lk, 0);
`endif

        // Post-reset table reads back as zero except fresh writes.
        for (int i = 0; i < 40; i++) begin
            lk_valid  = ($urandom_range(0, 1) != 0);
            cfg_valid = ($urandom_range(0, 1) != 0);
            lk_addr   = AW'($urandom);
            cfg_addr  = AW'($urandom);
            cfg_we    = ($urandom_range(0, 2) == 0) ? NC'($urandom) : NC'(0);
            cfg_din   = $urandom;
            tick();
        end
        set_idle();
        repeat (RL + 1) tick();
        check("drain_queue_end", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
